// File: rtl/rel_addr_agu_if.sv
// Decoder-to-AGU bus: access strobes, pointer select/load, per-pointer config, and the
// resulting memory address and wrap flag.
interface rel_addr_agu_if #(
  parameter int unsigned MDATAW = 8,
  parameter int unsigned PSELW  = 2
);
  logic              srf;
  logic              ldi;
  logic [PSELW-1:0]  psel;
  logic              pinc;
  logic              pld;
  logic [MDATAW-1:0] in;
  logic [MDATAW-1:0] addr;
  logic              cfg_we;
  logic [1:0]        cfg_mode;
  logic [MDATAW-1:0] cfg_step;
  logic [MDATAW-1:0] cfg_len;
  logic [MDATAW-1:0] out;
  logic              wrap;

  modport master (
    output srf, ldi, psel, pinc, pld, in, addr, cfg_we, cfg_mode, cfg_step, cfg_len,
    input  out, wrap
  );

  modport slave (
    input  srf, ldi, psel, pinc, pld, in, addr, cfg_we, cfg_mode, cfg_step, cfg_len,
    output out, wrap
  );
endinterface

// File: rtl/rel_addr_agu.sv
// Multi-pointer address generator: pointer+offset addressing with optional bit-reversed
// index and circular post-increment per pointer.
module rel_addr_agu #(
  parameter int unsigned MDATAW = 8,
  parameter int unsigned NPTR   = 4,
  parameter int unsigned FFTSIZ = 3,
  parameter bit          USEFFT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  rel_addr_agu_if.slave bus
);
  localparam int unsigned PSELW = (NPTR > 1) ? $clog2(NPTR) : 1;
  localparam int unsigned AW    = MDATAW + 1;

  typedef struct packed {
    logic [1:0]        mode;
    logic [MDATAW-1:0] step;
    logic [MDATAW-1:0] len;
  } ptr_cfg_t;

  logic [MDATAW-1:0] ptr_q [NPTR];
  ptr_cfg_t          cfg_q [NPTR];
  logic              wrap_q;

  logic              acc;
  logic              sel_ok;
  logic [PSELW-1:0]  rd_idx;
  logic [MDATAW-1:0] cur_ptr;
  logic [MDATAW-1:0] eff_ptr;
  logic [MDATAW-1:0] ptr_nxt;
  ptr_cfg_t          cur_cfg;
  logic [AW-1:0]     sum;
  logic              wrap_hit;

  // Out-of-range selects read pointer 0 and suppress all writes.
  assign acc     = bus.srf | bus.ldi;
  assign sel_ok  = ({1'b0, bus.psel} < (PSELW + 1)'(NPTR));
  assign rd_idx  = sel_ok ? bus.psel : '0;
  assign cur_ptr = ptr_q[rd_idx];
  assign cur_cfg = cfg_q[rd_idx];

  // Effective index: low FFTSIZ bits mirrored in bit-reverse modes.
  always_comb begin
    eff_ptr = cur_ptr;
    if (USEFFT && cur_cfg.mode[1]) begin
      for (int unsigned i = 0; i < FFTSIZ; i++) begin
        eff_ptr[i] = cur_ptr[FFTSIZ-1-i];
      end
    end
  end

  assign bus.out  = acc ? (eff_ptr + bus.addr) : bus.addr;
  assign bus.wrap = wrap_q;

  // Signed MDATAW+1 post-increment with a single modulo correction.
  always_comb begin
    sum      = {1'b0, cur_ptr} + {cur_cfg.step[MDATAW-1], cur_cfg.step};
    ptr_nxt  = sum[MDATAW-1:0];
    wrap_hit = 1'b0;
    if (cur_cfg.mode[0] && (cur_cfg.len != '0)) begin
      if (!cur_cfg.step[MDATAW-1]) begin
        if (sum >= {1'b0, cur_cfg.len}) begin
          ptr_nxt  = MDATAW'(sum - {1'b0, cur_cfg.len});
          wrap_hit = 1'b1;
        end
      end else if (sum[MDATAW]) begin
        ptr_nxt  = MDATAW'(sum + {1'b0, cur_cfg.len});
        wrap_hit = 1'b1;
      end
    end
  end

  // Pointer load beats post-increment; config writes never affect this cycle's access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPTR; i++) begin
        ptr_q[i] <= '0;
        cfg_q[i] <= '{mode: 2'b00, step: MDATAW'(1), len: '0};
      end
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (sel_ok) begin
        if (bus.pld) begin
          ptr_q[rd_idx] <= bus.in;
        end else if (acc && bus.pinc) begin
          ptr_q[rd_idx] <= ptr_nxt;
          wrap_q        <= wrap_hit;
        end
        if (bus.cfg_we) begin
          cfg_q[rd_idx] <= '{mode: bus.cfg_mode, step: bus.cfg_step, len: bus.cfg_len};
        end
      end
    end
  end
endmodule

// File: tb/tb_rel_addr_agu.sv
// Directed and randomized checks of rel_addr_agu against an integer-arithmetic reference model.
module tb_rel_addr_agu;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] last_out;

  rel_addr_agu_if #(.MDATAW(8), .PSELW(2)) b ();
  rel_addr_agu_if #(.MDATAW(8), .PSELW(2)) b2 ();

  rel_addr_agu #(.MDATAW(8), .NPTR(4), .FFTSIZ(3), .USEFFT(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  rel_addr_agu #(.MDATAW(8), .NPTR(4), .FFTSIZ(3), .USEFFT(1'b0)) dut_nofft (
    .clk(clk), .rst(rst), .bus(b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [7:0] m_ptr  [4];
  logic [1:0] m_mode [4];
  logic [7:0] m_step [4];
  logic [7:0] m_len  [4];
  logic       m_wrap;

  function automatic logic [7:0] exp_out(input logic acc, input logic [1:0] ps, input logic [7:0] ad);
    int p;
    int rev;
    if (!acc) return ad;
    p = int'(m_ptr[ps]);
    if (m_mode[ps][1]) begin
      rev = ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
      p   = (p & ~7) | rev;
    end
    return 8'((p + int'(ad)) % 256);
  endfunction

  task automatic model_edge(input logic r, s, l, input logic [1:0] ps, input logic pi, pl,
                            input logic [7:0] din, input logic cw, input logic [1:0] cm,
                            input logic [7:0] cs, cl);
    int n;
    int st;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_ptr[i] = 8'd0; m_mode[i] = 2'b00; m_step[i] = 8'd1; m_len[i] = 8'd0;
      end
      m_wrap = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    if (pl) begin
      m_ptr[ps] = din;
    end else if ((s || l) && pi) begin
      st = int'($signed(m_step[ps]));
      n  = int'(m_ptr[ps]) + st;
      if (m_mode[ps][0] && m_len[ps] != 8'd0) begin
        if (st >= 0 && n >= int'(m_len[ps])) begin
          n = n - int'(m_len[ps]); m_wrap = 1'b1;
        end else if (st < 0 && n < 0) begin
          n = n + int'(m_len[ps]); m_wrap = 1'b1;
        end
      end
      m_ptr[ps] = 8'(n);
    end
    if (cw) begin
      m_mode[ps] = cm; m_step[ps] = cs; m_len[ps] = cl;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational address, clock, check wrap.
  task automatic cyc(input logic r, s, l, input logic [1:0] ps, input logic pi, pl,
                     input logic [7:0] din, ad, input logic cw, input logic [1:0] cm,
                     input logic [7:0] cs, cl, input string tag);
    rst = r; b.srf = s; b.ldi = l; b.psel = ps; b.pinc = pi; b.pld = pl; b.in = din;
    b.addr = ad; b.cfg_we = cw; b.cfg_mode = cm; b.cfg_step = cs; b.cfg_len = cl;
    #3;
    last_out = b.out;
    if (!r) chk({tag, " out"}, 32'(b.out), 32'(exp_out(s | l, ps, ad)));
    @(posedge clk);
    model_edge(r, s, l, ps, pi, pl, din, cw, cm, cs, cl);
    #1;
    chk({tag, " wrap"}, 32'(b.wrap), 32'(m_wrap));
  endtask

  logic [7:0] t4_exp [8];
  logic [7:0] old;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    t4_exp  = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
    rst = 1'b1;
    {b.srf, b.ldi, b.psel, b.pinc, b.pld, b.in, b.addr, b.cfg_we, b.cfg_mode, b.cfg_step, b.cfg_len} = '0;
    {b2.srf, b2.ldi, b2.psel, b2.pinc, b2.pld, b2.in, b2.addr, b2.cfg_we, b2.cfg_mode, b2.cfg_step, b2.cfg_len} = '0;
    @(posedge clk);
    #1;

    // T1 reset
    cyc(1, 0, 0, 2'd0, 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T1 rst");
    cyc(0, 1, 0, 2'd0, 0, 0, 8'd0, 8'd5, 0, 2'b00, 8'd0, 8'd0, "T1 acc");
    chk("T1 out5", 32'(last_out), 32'd5);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 2'(i), 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T1 ptr");

    // T2 linear step 3 from 10
    cyc(0, 0, 0, 2'd1, 0, 1, 8'd10, 8'd0, 1, 2'b00, 8'd3, 8'd0, "T2 setup");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 2'd1, 1, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T2 inc");
      chk("T2 seq", 32'(last_out), 32'(10 + 3 * i));
    end
    cyc(0, 1, 0, 2'd1, 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T2 final");
    chk("T2 ptr19", 32'(last_out), 32'd19);

    // T3 circular wrap
    cyc(0, 0, 0, 2'd2, 0, 1, 8'd3, 8'd0, 1, 2'b01, 8'd2, 8'd5, "T3 setup");
    cyc(0, 0, 1, 2'd2, 1, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T3 inc");
    chk("T3 out3", 32'(last_out), 32'd3);
    chk("T3 wrap1", 32'(b.wrap), 32'd1);
    cyc(0, 1, 0, 2'd2, 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T3 after");
    chk("T3 ptr0", 32'(last_out), 32'd0);
    chk("T3 wrap0", 32'(b.wrap), 32'd0);

    // T4 bit-reverse sweep
    cyc(0, 0, 0, 2'd0, 0, 1, 8'd0, 8'd0, 1, 2'b10, 8'd1, 8'd0, "T4 setup");
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 2'd0, 1, 0, 8'd0, 8'h10, 0, 2'b00, 8'd0, 8'd0, "T4 inc");
      chk("T4 rev", 32'(last_out), 32'(t4_exp[i]));
    end

    // T5 pld priority over increment, then negative circular step
    cyc(0, 1, 0, 2'd1, 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T5 peek");
    old = last_out;
    cyc(0, 0, 1, 2'd1, 1, 1, 8'd7, 8'd2, 0, 2'b00, 8'd0, 8'd0, "T5 prio");
    chk("T5 oldaddr", 32'(last_out), 32'(8'(old + 8'd2)));
    cyc(0, 1, 0, 2'd1, 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T5 ptr7");
    chk("T5 ptr7c", 32'(last_out), 32'd7);
    cyc(0, 0, 0, 2'd3, 0, 1, 8'd0, 8'd0, 1, 2'b01, 8'hFF, 8'd4, "T5 neg setup");
    cyc(0, 0, 1, 2'd3, 1, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T5 neg inc");
    chk("T5 negwrap", 32'(b.wrap), 32'd1);
    cyc(0, 1, 0, 2'd3, 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T5 neg ptr");
    chk("T5 ptr3", 32'(last_out), 32'd3);

    // T6 reset mid-loop
    cyc(0, 0, 0, 2'd1, 0, 1, 8'd10, 8'd0, 1, 2'b00, 8'd3, 8'd0, "T6 setup");
    cyc(0, 0, 1, 2'd1, 1, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T6 inc");
    cyc(1, 0, 1, 2'd1, 1, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T6 rst");
    cyc(0, 1, 0, 2'd1, 0, 0, 8'd0, 8'd0, 0, 2'b00, 8'd0, 8'd0, "T6 ptr");
    chk("T6 ptr0", 32'(last_out), 32'd0);

    // T6 bit-reverse mode without reversal hardware reads linearly
    b2.psel = 2'd0; b2.pld = 1'b1; b2.in = 8'd6; b2.cfg_we = 1'b1; b2.cfg_mode = 2'b10;
    b2.cfg_step = 8'd1; b2.cfg_len = 8'd0;
    @(posedge clk);
    #1;
    b2.pld = 1'b0; b2.cfg_we = 1'b0; b2.srf = 1'b1; b2.addr = 8'h10;
    #3;
    chk("T6 nofft", 32'(b2.out), 32'h16);
    b2.srf = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic, keeping |step| < len for circular configs
    for (int k = 0; k < 400; k++) begin
      logic r, s, l, pi, pl, cw;
      logic [1:0] ps, cm;
      logic [7:0] din, ad, cs, cl;
      int mag;
      r  = ($urandom_range(0, 59) == 0);
      s  = $urandom_range(0, 1) == 1;
      l  = $urandom_range(0, 2) == 0;
      ps = 2'($urandom_range(0, 3));
      pi = $urandom_range(0, 3) != 0;
      pl = $urandom_range(0, 7) == 0;
      cw = $urandom_range(0, 7) == 0;
      din = 8'($urandom);
      ad  = 8'($urandom);
      cm  = 2'($urandom_range(0, 3));
      cl  = 8'($urandom_range(0, 20));
      if (cl >= 8'd2) begin
        mag = $urandom_range(0, int'(cl) - 1);
        cs  = ($urandom_range(0, 1) == 1) ? 8'(-mag) : 8'(mag);
      end else if (cl == 8'd1) begin
        cs = 8'd0;
      end else begin
        cs = 8'($urandom);
      end
      cyc(r, s, l, ps, pi, pl, din, ad, cw, cm, cs, cl, "RND");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
